// File: rtl/dram_bridge_mb_pkg.sv
// Shared types and helpers for the multi-beat DRAM bridge.
package bridge_mb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B,
    ST_OUT
  } state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Byte address of one beat; caller truncates to its address width.
  function automatic logic [63:0] beat_addr(input logic [63:0] base,
                                            input logic [63:0] idx,
                                            input logic [63:0] rec_bytes,
                                            input logic [63:0] beat,
                                            input logic [63:0] word_bytes);
    return base + idx * rec_bytes + beat * word_bytes;
  endfunction

endpackage

// File: rtl/dram_bridge_mb.sv
// Client-to-AXI4-Lite bridge: one record per request, split into BEATS
// single-word transactions, with per-beat retry and an abort flag.
module dram_bridge_mb
  import bridge_mb_pkg::*;
#(
  parameter int unsigned        DATA_W    = 64,
  parameter int unsigned        ADDR_W    = 17,
  parameter int unsigned        IDX_W     = 8,
  parameter int unsigned        BEATS     = 1,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = 17'h10000,
  parameter int unsigned        MAX_RETRY = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      C_in_valid,
  input  logic                      C_r_wb,
  input  logic [IDX_W-1:0]          C_addr,
  input  logic [BEATS*DATA_W-1:0]   C_data_w,
  output logic                      C_out_valid,
  output logic [BEATS*DATA_W-1:0]   C_data_r,
  output logic                      C_err,
  output logic                      AR_VALID,
  output logic [ADDR_W-1:0]         AR_ADDR,
  input  logic                      AR_READY,
  input  logic                      R_VALID,
  input  logic [DATA_W-1:0]         R_DATA,
  input  logic [1:0]                R_RESP,
  output logic                      R_READY,
  output logic                      AW_VALID,
  output logic [ADDR_W-1:0]         AW_ADDR,
  input  logic                      AW_READY,
  output logic                      W_VALID,
  output logic [DATA_W-1:0]         W_DATA,
  input  logic                      W_READY,
  input  logic                      B_VALID,
  input  logic [1:0]                B_RESP,
  output logic                      B_READY
);

  localparam int unsigned REC_W   = BEATS * DATA_W;
  localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  state_e             state_q, state_d;
  logic               rd_q, rd_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [REC_W-1:0]   rec_q, rec_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               err_q, err_d;

  logic [ADDR_W-1:0]  cur_addr;
  logic [31:0]        slot_lo;
  logic               resp_hit;
  logic [1:0]         resp;
  state_e             retry_state;

  assign cur_addr = ADDR_W'(beat_addr(64'(BASE_ADDR), 64'(idx_q),
                                      64'(REC_W / 8), 64'(beat_q),
                                      64'(DATA_W / 8)));
  assign slot_lo  = 32'(beat_q) * 32'(DATA_W);

  // R and B responses share one OKAY/retry/abort decision; only the
  // channel to re-issue on differs.
  assign resp_hit    = (state_q == ST_R && R_VALID) || (state_q == ST_B && B_VALID);
  assign resp        = (state_q == ST_R) ? R_RESP : B_RESP;
  assign retry_state = (state_q == ST_R) ? ST_AR : ST_AW;

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    idx_d   = idx_q;
    rec_d   = rec_q;
    beat_d  = beat_q;
    retry_d = retry_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (C_in_valid) begin
          rd_d    = C_r_wb;
          idx_d   = C_addr;
          rec_d   = C_data_w;
          beat_d  = '0;
          retry_d = '0;
          err_d   = 1'b0;
          state_d = C_r_wb ? ST_AR : ST_AW;
        end
      end
      ST_AR: if (AR_READY) state_d = ST_R;
      ST_AW: if (AW_READY) state_d = ST_W;
      ST_W:  if (W_READY)  state_d = ST_B;
      ST_R, ST_B: begin
        if (resp_hit) begin
          if (resp == RESP_OKAY) begin
            if (state_q == ST_R) rec_d[slot_lo +: DATA_W] = R_DATA;
            retry_d = '0;
            if (beat_q == LAST_BEAT) begin
              state_d = ST_OUT;
            end else begin
              beat_d  = beat_q + 1'b1;
              state_d = retry_state;
            end
          end else if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = retry_state;
          end else begin
            err_d   = 1'b1;
            state_d = ST_OUT;
          end
        end
      end
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rd_q    <= 1'b0;
      idx_q   <= '0;
      rec_q   <= '0;
      beat_q  <= '0;
      retry_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      idx_q   <= idx_d;
      rec_q   <= rec_d;
      beat_q  <= beat_d;
      retry_q <= retry_d;
      err_q   <= err_d;
    end
  end

  // Outputs are pure decodes of registered state; payloads are zero when idle.
  assign AR_VALID    = (state_q == ST_AR);
  assign AR_ADDR     = AR_VALID ? cur_addr : '0;
  assign R_READY     = (state_q == ST_R);
  assign AW_VALID    = (state_q == ST_AW);
  assign AW_ADDR     = AW_VALID ? cur_addr : '0;
  assign W_VALID     = (state_q == ST_W);
  assign W_DATA      = W_VALID ? rec_q[slot_lo +: DATA_W] : '0;
  assign B_READY     = (state_q == ST_B);
  assign C_out_valid = (state_q == ST_OUT);
  assign C_err       = C_out_valid && err_q;
  assign C_data_r    = (C_out_valid && rd_q && !err_q) ? rec_q : '0;

endmodule

// File: tb/tb_dram_bridge_mb.sv
// Scoreboard bench: one single-beat and one four-beat bridge share a
// reactive AXI4-Lite slave; sel picks which one is exercised.
module tb_dram_bridge_mb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, sel;
  logic         c_in_valid, c_r_wb;
  logic [7:0]   c_addr;
  logic [255:0] c_data_w;
  logic         ar_ready, r_valid, aw_ready, w_ready, b_valid;
  logic [63:0]  r_data;
  logic [1:0]   r_resp, b_resp;

  logic co_a, ce_a, arv_a, rr_a, awv_a, wv_a, br_a;
  logic [63:0] cdr_a, wd_a;
  logic [16:0] ara_a, awa_a;
  logic co_b, ce_b, arv_b, rr_b, awv_b, wv_b, br_b;
  logic [255:0] cdr_b;
  logic [63:0]  wd_b;
  logic [16:0]  ara_b, awa_b;

  dram_bridge_mb #(.BEATS(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .C_in_valid(c_in_valid & ~sel), .C_r_wb(c_r_wb), .C_addr(c_addr),
    .C_data_w(c_data_w[63:0]),
    .C_out_valid(co_a), .C_data_r(cdr_a), .C_err(ce_a),
    .AR_VALID(arv_a), .AR_ADDR(ara_a), .AR_READY(ar_ready),
    .R_VALID(r_valid), .R_DATA(r_data), .R_RESP(r_resp), .R_READY(rr_a),
    .AW_VALID(awv_a), .AW_ADDR(awa_a), .AW_READY(aw_ready),
    .W_VALID(wv_a), .W_DATA(wd_a), .W_READY(w_ready),
    .B_VALID(b_valid), .B_RESP(b_resp), .B_READY(br_a)
  );

  dram_bridge_mb #(.BEATS(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .C_in_valid(c_in_valid & sel), .C_r_wb(c_r_wb), .C_addr(c_addr),
    .C_data_w(c_data_w),
    .C_out_valid(co_b), .C_data_r(cdr_b), .C_err(ce_b),
    .AR_VALID(arv_b), .AR_ADDR(ara_b), .AR_READY(ar_ready),
    .R_VALID(r_valid), .R_DATA(r_data), .R_RESP(r_resp), .R_READY(rr_b),
    .AW_VALID(awv_b), .AW_ADDR(awa_b), .AW_READY(aw_ready),
    .W_VALID(wv_b), .W_DATA(wd_b), .W_READY(w_ready),
    .B_VALID(b_valid), .B_RESP(b_resp), .B_READY(br_b)
  );

  // Outputs of the selected DUT.
  logic         c_out_valid, c_err, ar_valid, r_ready, aw_valid, w_valid, b_ready;
  logic [255:0] c_data_r;
  logic [16:0]  ar_addr, aw_addr;
  logic [63:0]  w_data;
  assign c_out_valid = sel ? co_b  : co_a;
  assign c_err       = sel ? ce_b  : ce_a;
  assign c_data_r    = sel ? cdr_b : {192'b0, cdr_a};
  assign ar_valid    = sel ? arv_b : arv_a;
  assign ar_addr     = sel ? ara_b : ara_a;
  assign r_ready     = sel ? rr_b  : rr_a;
  assign aw_valid    = sel ? awv_b : awv_a;
  assign aw_addr     = sel ? awa_b : awa_a;
  assign w_valid     = sel ? wv_b  : wv_a;
  assign w_data      = sel ? wd_b  : wd_a;
  assign b_ready     = sel ? br_b  : br_a;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int ar_stall = 0;
  logic out_prev = 1'b0;
  logic [16:0] ar_lat = '0, aw_lat = '0;

  logic [63:0]  mem [logic [16:0]];
  logic [16:0]  exp_ar [$];
  logic [80:0]  exp_wr [$];
  logic [256:0] exp_out [$];
  logic [1:0]   resp_q [$];

  task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event want none", nm);
  endtask

  function automatic logic [383:0] all_outs();
    return 384'({c_out_valid, c_err, c_data_r, ar_valid, ar_addr, r_ready,
                 aw_valid, aw_addr, w_valid, w_data, b_ready});
  endfunction

  // Slave drives at the falling edge, then the monitor scores the
  // handshakes that will complete on the next rising edge.
  task automatic slave_and_monitor();
    logic [16:0]  a;
    logic [80:0]  ew;
    logic [256:0] eo;
    forever begin
      @(negedge clk);
      if (ar_valid && ar_stall > 0) begin
        ar_ready = 1'b0;
        ar_stall--;
      end else begin
        ar_ready = ar_valid;
      end
      aw_ready = aw_valid;
      w_ready  = w_valid;
      r_valid  = r_ready;
      r_data   = (r_ready && mem.exists(ar_lat)) ? mem[ar_lat] : '0;
      r_resp   = (r_ready && resp_q.size() > 0) ? resp_q[0] : 2'b00;
      b_valid  = b_ready;
      b_resp   = (b_ready && resp_q.size() > 0) ? resp_q[0] : 2'b00;
      if (rst_n) begin
        if (ar_valid && ar_ready) begin
          ar_lat = ar_addr;
          if (exp_ar.size() == 0) unexpected("ar_hs");
          else begin a = exp_ar.pop_front(); chk("ar_addr", 384'(ar_addr), 384'(a)); end
        end
        if ((r_valid && r_ready) || (b_valid && b_ready))
          if (resp_q.size() > 0) void'(resp_q.pop_front());
        if (aw_valid && aw_ready) aw_lat = aw_addr;
        if (w_valid && w_ready) begin
          if (exp_wr.size() == 0) unexpected("w_hs");
          else begin ew = exp_wr.pop_front(); chk("w_beat", 384'({aw_lat, w_data}), 384'(ew)); end
        end
        if (out_prev) chk("out_pulse", 384'(c_out_valid), 384'(0));
        if (c_out_valid) begin
          done_cnt++;
          if (exp_out.size() == 0) unexpected("c_out");
          else begin eo = exp_out.pop_front(); chk("c_out", 384'({c_err, c_data_r}), 384'(eo)); end
        end
        out_prev = c_out_valid;
      end else begin
        out_prev = 1'b0;
      end
    end
  endtask

  // Issue one request; returns at the cycle after acceptance, +1 time unit.
  task automatic req(input logic s, input logic rd, input logic [7:0] idx, input logic [255:0] d);
    @(posedge clk); #1;
    sel = s; c_in_valid = 1'b1; c_r_wb = rd; c_addr = idx; c_data_w = d;
    @(posedge clk); #1;
    c_in_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int start;
    bit seen;
    start = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      if (done_cnt != start) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: got no completion want C_out_valid within 200 cycles", nm);
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; c_in_valid = 1'b0; c_r_wb = 1'b0;
    c_addr = '0; c_data_w = '0;
    ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = '0;
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = '0;
    fork
      slave_and_monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs_a", all_outs(), '0);
    sel = 1'b1; #1;
    chk("reset_outs_b", all_outs(), '0);
    rst_n = 1'b1;

    // Single-beat read, zero-wait slave.
    mem[17'h10028] = 64'hDEADBEEF_01234567;
    exp_ar.push_back(17'h10028);
    exp_out.push_back({1'b0, 256'h0000000000000000_0000000000000000_0000000000000000_DEADBEEF01234567});
    req(1'b0, 1'b1, 8'h05, '0);
    chk("rd_latency", 384'({ar_valid, ar_addr}), 384'({1'b1, 17'h10028}));
    wait_done("rd1");

    // Four-beat write.
    for (int i = 0; i < 4; i++)
      exp_wr.push_back({17'(17'h10040 + 8 * i), 64'(i + 1)});
    exp_out.push_back('0);
    req(1'b1, 1'b0, 8'h02, {64'h4, 64'h3, 64'h2, 64'h1});
    chk("wr_latency", 384'({aw_valid, aw_addr}), 384'({1'b1, 17'h10040}));
    wait_done("wr4");

    // Single-beat read: SLVERR once, then OKAY.
    mem[17'h10038] = 64'h01234567_89ABCDEF;
    resp_q.push_back(2'b10);
    exp_ar.push_back(17'h10038);
    exp_ar.push_back(17'h10038);
    exp_out.push_back({1'b0, 256'h0123456789ABCDEF});
    req(1'b0, 1'b1, 8'h07, '0);
    wait_done("rd_retry");

    // Four-beat read with a retry on beat 1; slots land in order.
    mem[17'h10020] = 64'hA0A0_0000_0000_0001;
    mem[17'h10028] = 64'hA1A1_0000_0000_0002;
    mem[17'h10030] = 64'hA2A2_0000_0000_0003;
    mem[17'h10038] = 64'hA3A3_0000_0000_0004;
    resp_q.push_back(2'b00);
    resp_q.push_back(2'b10);
    exp_ar.push_back(17'h10020);
    exp_ar.push_back(17'h10028);
    exp_ar.push_back(17'h10028);
    exp_ar.push_back(17'h10030);
    exp_ar.push_back(17'h10038);
    exp_out.push_back({1'b0, 64'hA3A3_0000_0000_0004, 64'hA2A2_0000_0000_0003,
                       64'hA1A1_0000_0000_0002, 64'hA0A0_0000_0000_0001});
    req(1'b1, 1'b1, 8'h01, '0);
    wait_done("rd4_retry");

    // Four-beat write: DECERR on every attempt of beat 0 -> abort.
    for (int i = 0; i < 4; i++) begin
      resp_q.push_back(2'b11);
      exp_wr.push_back({17'h10060, 64'hCAFE});
    end
    exp_out.push_back({1'b1, 256'b0});
    req(1'b1, 1'b0, 8'h03, {64'hD3, 64'hD2, 64'hD1, 64'hCAFE});
    wait_done("wr_abort");

    // Single-beat read aborted after retries: data forced to zero.
    mem[17'h10010] = 64'h7777_8888_9999_AAAA;
    for (int i = 0; i < 4; i++) begin
      resp_q.push_back(2'b10);
      exp_ar.push_back(17'h10010);
    end
    exp_out.push_back({1'b1, 256'b0});
    req(1'b0, 1'b1, 8'h02, '0);
    wait_done("rd_abort");

    // Four-beat read: beat 0 good, beat 1 aborts; filled slot discarded.
    mem[17'h10000] = 64'h1234_5678_9ABC_DEF0;
    resp_q.push_back(2'b00);
    exp_ar.push_back(17'h10000);
    for (int i = 0; i < 4; i++) begin
      resp_q.push_back(2'b10);
      exp_ar.push_back(17'h10008);
    end
    exp_out.push_back({1'b1, 256'b0});
    req(1'b1, 1'b1, 8'h00, '0);
    wait_done("rd4_abort");

    // AR_READY held low for 10 cycles; stray requests meanwhile.
    mem[17'h10048] = 64'h5555_AAAA_0F0F_F0F0;
    ar_stall = 10;
    exp_ar.push_back(17'h10048);
    exp_out.push_back({1'b0, 256'h5555AAAA0F0FF0F0});
    req(1'b0, 1'b1, 8'h09, '0);
    c_r_wb = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      chk("ar_hold", 384'({ar_valid, ar_addr}), 384'({1'b1, 17'h10048}));
      c_in_valid = (i % 2) == 1;
    end
    @(posedge clk); #1;
    c_in_valid = 1'b0;
    wait_done("rd_stall");

    // Reset while in W, then a normal four-beat read.
    req(1'b1, 1'b0, 8'h04, {64'hE3, 64'hE2, 64'hE1, 64'hE0});
    for (int i = 0; i < 10 && !w_valid; i++) begin @(posedge clk); #1; end
    chk("in_w_state", 384'(w_valid), 384'(1));
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("reset_mid_outs", all_outs(), '0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem[17'(17'h10080 + 8 * i)] = 64'(64'hB0 + i);
      exp_ar.push_back(17'(17'h10080 + 8 * i));
    end
    exp_out.push_back({1'b0, 64'hB3, 64'hB2, 64'hB1, 64'hB0});
    req(1'b1, 1'b1, 8'h04, '0);
    wait_done("rd_after_reset");

    chk("queues_drained", 384'(exp_ar.size() + exp_wr.size() + exp_out.size() + resp_q.size()), 384'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
